// File: rtl/mips_pipeline_ctrl_pkg.sv
// Shared types and helpers for the MIPS pipeline hazard/forwarding controller.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: entry_t scoreboard entry, FWD_NONE select code, entry accessors.
package mips_pipeline_ctrl_pkg;

  // Widest register index the scoreboard can hold; narrower indices are zero-extended.
  localparam int MAX_REG_W = 8;

  // Forward-select code meaning "read the register file".
  localparam int FWD_NONE = 0;

  typedef struct packed {
    logic                 valid;
    logic [MAX_REG_W-1:0] dst;
    logic                 writes;
    logic                 is_load;
  } entry_t;

  function automatic entry_t make_entry(input logic                 valid,
                                        input logic [MAX_REG_W-1:0] dst,
                                        input logic                 writes,
                                        input logic                 is_load);
    entry_t e;
    e.valid   = valid;
    e.dst     = dst;
    e.writes  = writes;
    e.is_load = is_load;
    return e;
  endfunction

  // True when this entry will produce the value of register r.
  // $0 is hard-wired zero, so nothing ever forwards into it.
  function automatic logic entry_match(input entry_t e, input logic [MAX_REG_W-1:0] r);
    return e.valid & e.writes & (e.dst == r) & (r != '0);
  endfunction

  function automatic logic entry_is_load(input entry_t e);
    return e.is_load;
  endfunction

endpackage

// File: rtl/mips_pipeline_ctrl_if.sv
// Issue-side bundle between the REG stage and the hazard/forwarding controller.
// Latency: wires only.
// Backpressure: stall from the controller holds PC/REG; no other flow control.
// master: REG stage (drives issue_* and branch_taken); slave: controller (drives stall, flush, fwd_*, stats).
interface mips_pipeline_ctrl_if #(
  parameter int STAGES = 4,
  parameter int REG_W  = 5
);
  localparam int D     = STAGES - 2;
  localparam int FWD_W = $clog2(STAGES - 1);

  logic             issue_valid;
  logic [REG_W-1:0] issue_rs;
  logic [REG_W-1:0] issue_rt;
  logic             issue_uses_rs;
  logic             issue_uses_rt;
  logic [REG_W-1:0] issue_dst;
  logic             issue_writes;
  logic             issue_is_load;
  logic             branch_taken;

  logic             stall;
  logic             flush;
  logic [FWD_W-1:0] fwd_rs;
  logic [FWD_W-1:0] fwd_rt;
  logic [D-1:0]     inflight_valid;
  logic [15:0]      stall_count;
  logic [15:0]      flush_count;

  modport master (
    output issue_valid, issue_rs, issue_rt, issue_uses_rs, issue_uses_rt,
           issue_dst, issue_writes, issue_is_load, branch_taken,
    input  stall, flush, fwd_rs, fwd_rt, inflight_valid, stall_count, flush_count
  );

  modport slave (
    input  issue_valid, issue_rs, issue_rt, issue_uses_rs, issue_uses_rt,
           issue_dst, issue_writes, issue_is_load, branch_taken,
    output stall, flush, fwd_rs, fwd_rt, inflight_valid, stall_count, flush_count
  );

endinterface

// File: rtl/mips_pipeline_ctrl_match.sv
// Priority search of the in-flight scoreboard for one source operand.
// Latency: combinational.
// Backpressure: none.
// Ports: ents (entries 1..D), reg_idx (operand) -> hit, idx (youngest matching k), load_at1.
module mips_pipeline_ctrl_match
  import mips_pipeline_ctrl_pkg::*;
#(
  parameter int D     = 2,
  parameter int FWD_W = 2
) (
  input  entry_t [D:1]         ents,
  input  logic [MAX_REG_W-1:0] reg_idx,
  output logic                 hit,
  output logic [FWD_W-1:0]     idx,
  output logic                 load_at1
);

  always_comb begin
    hit = 1'b0;
    idx = FWD_W'(FWD_NONE);
    // Walk oldest to youngest so the youngest producer overrides.
    for (int k = D; k >= 1; k--) begin
      if (entry_match(ents[k], reg_idx)) begin
        hit = 1'b1;
        idx = FWD_W'(k);
      end
    end
    // A load still in EX has no result yet; this is the only case that must stall.
    load_at1 = entry_match(ents[1], reg_idx) & entry_is_load(ents[1]);
  end

endmodule

// File: rtl/mips_pipeline_ctrl.sv
// Hazard/forwarding controller: scoreboard of instructions past REG, drives stall/flush/forward selects.
// Latency: outputs combinational from issue inputs and the registered scoreboard; scoreboard shifts every clock.
// Backpressure: stall holds PC/REG for one cycle per load-use and injects a bubble into EX.
// Ports: clk, rst (synchronous, active-high), bus (mips_pipeline_ctrl_if.slave).
// Optional statistics counters: define MIPS_PIPELINE_CTRL_STATS_EN.
// STAGES must be >= 4 and REG_W <= MAX_REG_W; bus must be instantiated with the same STAGES/REG_W.
module mips_pipeline_ctrl
  import mips_pipeline_ctrl_pkg::*;
#(
  parameter int STAGES  = 4,
  parameter int REG_W   = 5,
  parameter bit DELAYED = 1'b1
) (
  input logic              clk,
  input logic              rst,
  mips_pipeline_ctrl_if.slave bus
);

  localparam int D     = STAGES - 2;
  localparam int FWD_W = $clog2(STAGES - 1);

  entry_t [D:1]     ents;
  entry_t           issue_ent;
  logic             hit_rs, hit_rt;
  logic             la1_rs, la1_rt;
  logic [FWD_W-1:0] k_rs, k_rt;
  logic             stall_i;
  logic             flush_i;

  mips_pipeline_ctrl_match #(.D(D), .FWD_W(FWD_W)) u_match_rs (
    .ents     (ents),
    .reg_idx  (MAX_REG_W'(bus.issue_rs)),
    .hit      (hit_rs),
    .idx      (k_rs),
    .load_at1 (la1_rs)
  );

  mips_pipeline_ctrl_match #(.D(D), .FWD_W(FWD_W)) u_match_rt (
    .ents     (ents),
    .reg_idx  (MAX_REG_W'(bus.issue_rt)),
    .hit      (hit_rt),
    .idx      (k_rt),
    .load_at1 (la1_rt)
  );

  // After one stall cycle the load has moved to e[2], so the stall self-clears.
  assign stall_i = bus.issue_valid &
                   ((bus.issue_uses_rs & la1_rs) | (bus.issue_uses_rt & la1_rt));

  // A stalled branch is re-presented next cycle; flush only once it actually issues.
  assign flush_i = !DELAYED & bus.issue_valid & bus.branch_taken & !stall_i;

  always_comb begin
    issue_ent = '0;
    if (bus.issue_valid && !stall_i) begin
      issue_ent = make_entry(1'b1, MAX_REG_W'(bus.issue_dst), bus.issue_writes, bus.issue_is_load);
    end
  end

  // Scoreboard shift: e[1] takes the issuing instruction (or a bubble), e[D] retires.
  always_ff @(posedge clk) begin
    if (rst) begin
      ents <= '0;
    end else begin
      ents[1] <= issue_ent;
      for (int k = 2; k <= D; k++) begin
        ents[k] <= ents[k-1];
      end
    end
  end

  always_comb begin
    bus.inflight_valid = '0;
    for (int k = 1; k <= D; k++) begin
      bus.inflight_valid[k-1] = ents[k].valid;
    end
  end

  assign bus.stall  = stall_i;
  assign bus.flush  = flush_i;
  assign bus.fwd_rs = (bus.issue_valid & bus.issue_uses_rs & hit_rs) ? k_rs : FWD_W'(FWD_NONE);
  assign bus.fwd_rt = (bus.issue_valid & bus.issue_uses_rt & hit_rt) ? k_rt : FWD_W'(FWD_NONE);

`ifdef MIPS_PIPELINE_CTRL_STATS_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_i && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (flush_i && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
    end
  end

  assign bus.stall_count = stall_cnt;
  assign bus.flush_count = flush_cnt;
`else
  assign bus.stall_count = '0;
  assign bus.flush_count = '0;
`endif

endmodule

// File: tb/tb_mips_pipeline_ctrl.sv
// Directed bench for mips_pipeline_ctrl: STAGES=4/DELAYED=0 (dut_a) and STAGES=6/DELAYED=1 (dut_b).
// Latency: n/a.
// Backpressure: n/a.
module tb_mips_pipeline_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  mips_pipeline_ctrl_if #(.STAGES(4), .REG_W(5)) bus_a ();
  mips_pipeline_ctrl_if #(.STAGES(6), .REG_W(5)) bus_b ();

  mips_pipeline_ctrl #(.STAGES(4), .REG_W(5), .DELAYED(1'b0)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  mips_pipeline_ctrl #(.STAGES(6), .REG_W(5), .DELAYED(1'b1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [4:0] rs, input logic urs,
                         input logic [4:0] rt, input logic urt, input logic [4:0] dst,
                         input logic wr, input logic ld, input logic br);
    bus_a.issue_valid   = v;
    bus_a.issue_rs      = rs;
    bus_a.issue_uses_rs = urs;
    bus_a.issue_rt      = rt;
    bus_a.issue_uses_rt = urt;
    bus_a.issue_dst     = dst;
    bus_a.issue_writes  = wr;
    bus_a.issue_is_load = ld;
    bus_a.branch_taken  = br;
    #1;
  endtask

  task automatic drive_b(input logic v, input logic [4:0] rs, input logic urs,
                         input logic [4:0] rt, input logic urt, input logic [4:0] dst,
                         input logic wr, input logic ld, input logic br);
    bus_b.issue_valid   = v;
    bus_b.issue_rs      = rs;
    bus_b.issue_uses_rs = urs;
    bus_b.issue_rt      = rt;
    bus_b.issue_uses_rt = urt;
    bus_b.issue_dst     = dst;
    bus_b.issue_writes  = wr;
    bus_b.issue_is_load = ld;
    bus_b.branch_taken  = br;
    #1;
  endtask

  initial begin
    drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;

    // ---- Reset: fill both pipes, then reset for 2 cycles ----
    drive_a(1, 0, 0, 0, 0, 5'd7, 1, 0, 0);
    drive_b(1, 0, 0, 0, 0, 5'd7, 1, 0, 0);
    tick();
    tick();
    chk("fill_a_inflight", 32'(bus_a.inflight_valid), 32'h3);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_a_inflight", 32'(bus_a.inflight_valid), 32'h0);
    chk("rst_b_inflight", 32'(bus_b.inflight_valid), 32'h0);
    chk("rst_a_stall",    32'(bus_a.stall),          32'h0);
    chk("rst_a_flush",    32'(bus_a.flush),          32'h0);
    chk("rst_a_fwd_rs",   32'(bus_a.fwd_rs),         32'h0);
    chk("rst_a_fwd_rt",   32'(bus_a.fwd_rt),         32'h0);
    chk("rst_a_stall_cnt", 32'(bus_a.stall_count),   32'h0);
    chk("rst_a_flush_cnt", 32'(bus_a.flush_count),   32'h0);

    // ---- ALU chain on dut_a ----
    drive_a(1, 0, 0, 0, 0, 5'd3, 1, 0, 0);            // add $3
    tick();
    drive_a(1, 5'd3, 1, 5'd0, 1, 5'd0, 1, 0, 0);      // rs=$3, rt=$0, writes $0
    chk("alu_fwd_rs_ex",  32'(bus_a.fwd_rs), 32'd1);
    chk("alu_fwd_rt_r0",  32'(bus_a.fwd_rt), 32'd0);
    tick();
    drive_a(1, 5'd3, 1, 5'd0, 1, 5'd9, 0, 0, 0);
    chk("alu_fwd_rs_mem", 32'(bus_a.fwd_rs), 32'd2);
    chk("alu_fwd_rt_w0",  32'(bus_a.fwd_rt), 32'd0);
    chk("alu_no_stall",   32'(bus_a.stall),  32'd0);
    tick();
    drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();

    // ---- Load-use on dut_a ----
    drive_a(1, 0, 0, 0, 0, 5'd4, 1, 1, 0);            // lw $4
    tick();
    drive_a(1, 5'd4, 1, 0, 0, 5'd6, 1, 0, 0);         // add rs=$4
    chk("lu_stall",       32'(bus_a.stall),  32'd1);
    chk("lu_flush",       32'(bus_a.flush),  32'd0);
    tick();
    chk("lu_bubble",      32'(bus_a.inflight_valid), 32'h2);
    chk("lu_stall_clear", 32'(bus_a.stall),  32'd0);
    chk("lu_fwd_rs",      32'(bus_a.fwd_rs), 32'd2);
    tick();
    drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();

    // ---- Youngest wins / deep forward on dut_b ----
    drive_b(1, 0, 0, 0, 0, 5'd5, 1, 0, 0);
    tick();
    drive_b(1, 0, 0, 0, 0, 5'd5, 1, 0, 0);
    tick();
    drive_b(1, 5'd5, 1, 5'd5, 0, 0, 0, 0, 0);
    chk("young_fwd_rs",   32'(bus_b.fwd_rs), 32'd1);
    chk("young_rt_unused", 32'(bus_b.fwd_rt), 32'd0);
    tick();
    drive_b(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick(); tick(); tick();
    drive_b(1, 0, 0, 0, 0, 5'd9, 1, 1, 0);            // load to $9
    tick();
    drive_b(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick(); tick();
    drive_b(1, 5'd9, 1, 5'd9, 1, 5'd1, 1, 0, 0);
    chk("deep_inflight",  32'(bus_b.inflight_valid), 32'h8);
    chk("deep_fwd_rs",    32'(bus_b.fwd_rs), 32'd4);
    chk("deep_fwd_rt",    32'(bus_b.fwd_rt), 32'd4);
    chk("deep_no_stall",  32'(bus_b.stall),  32'd0);
    drive_b(1, 5'd9, 0, 0, 0, 0, 0, 0, 1);            // taken branch, delay slot kept
    chk("b_delayed_flush", 32'(bus_b.flush), 32'd0);
    tick();
    drive_b(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // ---- Branch on dut_a (slot squashed) ----
    drive_a(1, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("br_flush",       32'(bus_a.flush), 32'd1);
    tick();
    drive_a(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("br_not_taken",   32'(bus_a.flush), 32'd0);
    tick();
    drive_a(1, 0, 0, 0, 0, 5'd8, 1, 1, 0);            // lw $8
    tick();
    drive_a(1, 5'd8, 1, 0, 0, 0, 0, 0, 1);            // beq on $8, taken
    chk("brst_stall",     32'(bus_a.stall), 32'd1);
    chk("brst_flush0",    32'(bus_a.flush), 32'd0);
    tick();
    chk("brst_flush1",    32'(bus_a.flush), 32'd1);
    chk("brst_stall0",    32'(bus_a.stall), 32'd0);
    drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // ---- Stats: third load-use ----
    drive_a(1, 0, 0, 0, 0, 5'd10, 1, 1, 0);
    tick();
    drive_a(1, 0, 0, 5'd10, 1, 5'd11, 1, 0, 0);
    chk("st3_stall",      32'(bus_a.stall), 32'd1);
    tick();
    drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
`ifdef MIPS_PIPELINE_CTRL_STATS_EN
    chk("stat_stall_cnt", 32'(bus_a.stall_count), 32'd3);
    chk("stat_flush_cnt", 32'(bus_a.flush_count), 32'd2);
    chk("stat_b_flush",   32'(bus_b.flush_count), 32'd0);
    // Flush every cycle well past the 16-bit limit.
    drive_a(1, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 65540; i++) tick();
    drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("stat_flush_sat", 32'(bus_a.flush_count), 32'hFFFF);
    chk("stat_stall_keep", 32'(bus_a.stall_count), 32'd3);
`else
    chk("stat_stall_off", 32'(bus_a.stall_count), 32'd0);
    chk("stat_flush_off", 32'(bus_a.flush_count), 32'd0);
    chk("stat_b_off",     32'(bus_b.flush_count), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
